lif_spike_net: RTL and testbench
================================

LIF_SPIKE_NET -- requirements
Module: lif_spike_net

Interface
REQ-001 Parameter N_NEUR, default 2: neuron count, legal range 2..8.
REQ-002 Parameter V_W, default 8: membrane potential width in bits, unsigned.
REQ-003 Parameter W_W, default 4: synaptic weight width in bits.
REQ-004 Parameter THRESH, default 8'd200: firing threshold, compared as v >= THRESH.
REQ-005 Parameter LEAK_SH, default 3: leak per update is v >> LEAK_SH.
REQ-006 Parameter REFRACT, default 3: refractory length in update ticks after a spike.
REQ-007 Parameter EXT_W, default 8'd64: charge added when ext_spike[i] is high.
REQ-008 clk  in  1  single clock; everything is on the rising edge.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 ena  in  1  update enable; when low, all neuron state holds.
REQ-011 ext_spike  in  N_NEUR  external stimulus, one bit per neuron, sampled on ticks.
REQ-012 cfg_we  in  1  weight write strobe.
REQ-013 cfg_addr  in  2*clog2(N_NEUR)  weight address; upper field is dst i, lower field is src j.
REQ-014 cfg_wdata  in  W_W  weight value to write.
REQ-015 spike  out  N_NEUR  registered spike vector.
REQ-016 spike_out  out  1  equal to spike[N_NEUR-1].
REQ-017 spike_cnt  out  8  saturating count of spike_out pulses.

Function
REQ-018 A tick is any rising edge with ena=1; one tick computes one full network update for all neurons.
REQ-019 For each neuron i: sum_i = v_i - (v_i>>LEAK_SH) + EXT_W*ext_spike[i] + Σ_j w[i][j]*spike[j], using the spike vector registered on the previous tick.
REQ-020 Sum width is V_W+W_W+clog2(N_NEUR)+1 bits; the result saturates to the range 0..2^V_W-1 before it is stored.
REQ-021 If the saturated sum >= THRESH: on that tick spike[i]<=1, v_i<=0, refr_i<=REFRACT; otherwise spike[i]<=0 and v_i<=saturated sum.
REQ-022 Spike latency: the spike is visible the cycle after the tick on which threshold was reached, and lasts exactly one tick.
REQ-023 Per-neuron states: IDLE (refr_i=0, integrating) and REFR (refr_i>0).
REQ-024 In REFR: v_i is held at 0, all inputs are ignored, spike[i]=0, and refr_i decrements once per tick; REFR->IDLE when refr_i reaches 0.
REQ-025 REFRACT=0: the neuron skips REFR and may fire on consecutive ticks.
REQ-026 A self-weight w[i][i] is legal and feeds back the neuron's own previous spike.
REQ-027 Weight writes happen on any edge with cfg_we=1, regardless of ena.
REQ-028 Write and tick on the same edge: the tick uses the old weight; the new weight applies from the next tick.
REQ-029 A write with either cfg_addr field >= N_NEUR is ignored.
REQ-030 When ena=0: v, refr, spike and spike_cnt all hold; spike is not forced low.
REQ-031 spike_cnt increments on each tick where spike_out goes to 1, and saturates at 255.

Reset
REQ-032 On rst_n low, asynchronously: all v_i=0, refr_i=0, spike=0, spike_cnt=0, all w[i][j]=0.
REQ-033 A reset during REFR or mid-integration discards all state; the first tick after release starts every neuron in IDLE.

Configuration
REQ-034 Macro LIF_INHIBIT_EN defined: weights are signed two's complement, and negative contributions may pull the sum below 0, which clamps to 0.
REQ-035 LIF_INHIBIT_EN undefined: weights are unsigned, and the sum only saturates at the top of the range.

Structure
REQ-036 Package lif_pkg holds the sum-width function and the state enum {IDLE, REFR}.
REQ-037 The package also holds the default parameter constants.
REQ-038 Sub-module lif_neuron holds one neuron's v, refr and spike plus its leak/threshold logic; it takes the summed synaptic input.
REQ-039 The top level holds the weight array, the per-destination adder trees, the config port and spike_cnt.

Verification
REQ-040 Drive ext_spike[0]=1 on every tick, weights 0 -> v0 = 64, 120, 169, 0 (spike[0]=1 after tick 4), then 3 refractory ticks with v0=0.
REQ-041 Set w[1][0]=15 and drive ext_spike[0] each tick -> neuron 1 gains 15 one tick after each spike[0] pulse, less leak.
REQ-042 Write w[1][0] on the same edge as a tick that sees spike[0]=1 -> the old weight is applied on that tick.
REQ-043 Force 300 spikes of neuron N-1 -> spike_cnt stops at 255.
REQ-044 Assert rst_n low mid-REFR -> next ticks show the neuron integrating with no refractory hold.
REQ-045 With LIF_INHIBIT_EN: w[1][0]=-8, v1=5, spike[0]=1 -> v1=0 (clamped); without the macro, weight 8 -> v1=5-0+8=13.

Source files
------------

// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types, default constants and width helper for the LIF spiking network
//
// Purpose : default parameter values, per-neuron state enum and the
//           synaptic sum width function used by lif_spike_net and lif_neuron.
// Ports   : none (package).
package lif_pkg;

  localparam int LIF_N_NEUR_DEF  = 2;
  localparam int LIF_V_W_DEF     = 8;
  localparam int LIF_W_W_DEF     = 4;
  localparam int LIF_THRESH_DEF  = 200;
  localparam int LIF_LEAK_SH_DEF = 3;
  localparam int LIF_REFRACT_DEF = 3;
  localparam int LIF_EXT_W_DEF   = 64;

  typedef enum logic {
    IDLE = 1'b0,
    REFR = 1'b1
  } lif_state_e;

  // One extra bit over the unsigned worst case keeps a sign bit available
  // for inhibitory (negative) sums.
  function automatic int lif_sum_w(input int v_w, input int w_w, input int n_neur);
    return v_w + w_w + $clog2(n_neur) + 1;
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// rtl/lif_neuron.sv - one leaky integrate-and-fire neuron with refractory hold
//
// Purpose : holds v, the refractory counter and the registered spike of a
//           single neuron; applies leak, saturation and the threshold test to
//           the synaptic input summed by the parent.
// Ports   : clk_i    clock
//           rst_ni   asynchronous active-low reset
//           ena_i    tick enable; state holds when low
//           syn_i    signed synaptic + external input for this tick
//           spike_o  registered spike
//           fire_o   high on a tick that will set spike_o
// Config  : LIF_INHIBIT_EN enables clamping of negative sums to zero.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int V_W     = LIF_V_W_DEF,
  parameter int S_W     = 14,
  parameter int THRESH  = LIF_THRESH_DEF,
  parameter int LEAK_SH = LIF_LEAK_SH_DEF,
  parameter int REFRACT = LIF_REFRACT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  ena_i,
  input  logic signed [S_W-1:0] syn_i,
  output logic                  spike_o,
  output logic                  fire_o
);

  localparam int R_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic signed [S_W-1:0] V_MAX = {{(S_W-V_W){1'b0}}, {V_W{1'b1}}};

  lif_state_e      state_q, state_d;
  logic [V_W-1:0]  v_q, v_d;
  logic [R_W-1:0]  refr_q, refr_d;
  logic            spike_q, spike_d;

  logic [V_W-1:0]         leak;
  logic signed [S_W-1:0]  v_ext, leak_ext, sum;
  logic [V_W-1:0]         v_sat;

  always_comb begin
    leak     = v_q >> LEAK_SH;
    v_ext    = S_W'(v_q);
    leak_ext = S_W'(leak);
    sum      = v_ext - leak_ext + syn_i;
`ifdef LIF_INHIBIT_EN
    if (sum < 0) begin
      v_sat = '0;
    end else if (sum > V_MAX) begin
      v_sat = '1;
    end else begin
      v_sat = sum[V_W-1:0];
    end
`else
    if (sum > V_MAX) begin
      v_sat = '1;
    end else begin
      v_sat = sum[V_W-1:0];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    refr_d  = refr_q;
    spike_d = spike_q;
    fire_o  = 1'b0;
    if (ena_i) begin
      case (state_q)
        IDLE: begin
          if (v_sat >= V_W'(THRESH)) begin
            fire_o  = 1'b1;
            spike_d = 1'b1;
            v_d     = '0;
            // With no refractory period the neuron stays in IDLE and may
            // fire again on the very next tick.
            if (REFRACT > 0) begin
              refr_d  = R_W'(REFRACT);
              state_d = REFR;
            end
          end else begin
            spike_d = 1'b0;
            v_d     = v_sat;
          end
        end
        REFR: begin
          spike_d = 1'b0;
          v_d     = '0;
          refr_d  = refr_q - R_W'(1);
          if (refr_q == R_W'(1)) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      v_q     <= '0;
      refr_q  <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      refr_q  <= refr_d;
      spike_q <= spike_d;
    end
  end

  assign spike_o = spike_q;

endmodule

// File: rtl/lif_spike_net.sv
// rtl/lif_spike_net.sv - fully connected network of LIF neurons with weight config port
//
// Purpose : weight matrix, per-destination synaptic adders, weight write
//           port and saturating spike counter of the last neuron.
// Ports   : clk        clock
//           rst_n      asynchronous active-low reset
//           ena        tick enable
//           ext_spike  external stimulus per neuron
//           cfg_we     weight write strobe
//           cfg_addr   {dst, src} weight address
//           cfg_wdata  weight value
//           spike      registered spike vector
//           spike_out  spike of the last neuron
//           spike_cnt  saturating count of spike_out pulses
// Config  : LIF_INHIBIT_EN makes weights signed two's complement.
module lif_spike_net
  import lif_pkg::*;
#(
  parameter int N_NEUR  = LIF_N_NEUR_DEF,
  parameter int V_W     = LIF_V_W_DEF,
  parameter int W_W     = LIF_W_W_DEF,
  parameter int THRESH  = LIF_THRESH_DEF,
  parameter int LEAK_SH = LIF_LEAK_SH_DEF,
  parameter int REFRACT = LIF_REFRACT_DEF,
  parameter int EXT_W   = LIF_EXT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [N_NEUR-1:0]             ext_spike,
  input  logic                          cfg_we,
  input  logic [2*$clog2(N_NEUR)-1:0]   cfg_addr,
  input  logic [W_W-1:0]                cfg_wdata,
  output logic [N_NEUR-1:0]             spike,
  output logic                          spike_out,
  output logic [7:0]                    spike_cnt
);

  localparam int AW  = $clog2(N_NEUR);
  localparam int S_W = lif_sum_w(V_W, W_W, N_NEUR);
  localparam logic [AW:0] N_L = (AW+1)'(N_NEUR);

  logic [W_W-1:0]         w_q [N_NEUR][N_NEUR];
  logic signed [S_W-1:0]  syn [N_NEUR];
  logic [N_NEUR-1:0]      fire;
  logic [7:0]             cnt_q, cnt_d;
  logic [AW-1:0]          cfg_dst, cfg_src;
  logic                   cfg_ok;
  logic                   unused_fire_lo;

  function automatic logic signed [S_W-1:0] w_ext(input logic [W_W-1:0] w);
`ifdef LIF_INHIBIT_EN
    return {{(S_W-W_W){w[W_W-1]}}, w};
`else
    return {{(S_W-W_W){1'b0}}, w};
`endif
  endfunction

  assign cfg_dst = cfg_addr[2*AW-1:AW];
  assign cfg_src = cfg_addr[AW-1:0];
  // Non-power-of-two sizes leave address codes with no weight behind them.
  assign cfg_ok  = ({1'b0, cfg_dst} < N_L) && ({1'b0, cfg_src} < N_L);

  // Being a register, a write on a tick edge only reaches the sum one tick later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEUR; i++) begin
        for (int j = 0; j < N_NEUR; j++) begin
          w_q[i][j] <= '0;
        end
      end
    end else if (cfg_we && cfg_ok) begin
      w_q[cfg_dst][cfg_src] <= cfg_wdata;
    end
  end

  always_comb begin
    for (int i = 0; i < N_NEUR; i++) begin
      syn[i] = ext_spike[i] ? S_W'(EXT_W) : '0;
      for (int j = 0; j < N_NEUR; j++) begin
        if (spike[j]) begin
          syn[i] = syn[i] + w_ext(w_q[i][j]);
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_NEUR; gi++) begin : g_neur
    lif_neuron #(
      .V_W     (V_W),
      .S_W     (S_W),
      .THRESH  (THRESH),
      .LEAK_SH (LEAK_SH),
      .REFRACT (REFRACT)
    ) u_neur (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .ena_i   (ena),
      .syn_i   (syn[gi]),
      .spike_o (spike[gi]),
      .fire_o  (fire[gi])
    );
  end

  // Only the last neuron feeds the counter.
  assign unused_fire_lo = ^fire[N_NEUR-2:0];

  always_comb begin
    cnt_d = cnt_q;
    if (fire[N_NEUR-1] && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign spike_out = spike[N_NEUR-1];
  assign spike_cnt = cnt_q;

endmodule

// File: tb/tb_lif_spike_net.sv
// tb/tb_lif_spike_net.sv - directed self-checking bench for lif_spike_net
module tb_lif_spike_net;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [1:0] ext_spike = 2'b00;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'b00;
  logic [3:0] cfg_wdata = 4'd0;
  logic [1:0] spike;
  logic       spike_out;
  logic [7:0] spike_cnt;
  logic [7:0] v0, v1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  lif_spike_net dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .ext_spike (ext_spike),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .spike     (spike),
    .spike_out (spike_out),
    .spike_cnt (spike_cnt)
  );

  assign v0 = dut.g_neur[0].u_neur.v_q;
  assign v1 = dut.g_neur[1].u_neur.v_q;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Behavioural network model: integer potentials and refractory counters.
  int         mv [N];
  int         mr [N];
  int         mw [N][N];
  int         mcnt;
  logic [1:0] ms;
  logic [1:0] nsp;
  int         s;

  function automatic int wval(input logic [3:0] d);
`ifdef LIF_INHIBIT_EN
    return d[3] ? int'(d) - 16 : int'(d);
`else
    return int'(d);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mv[i] = 0;
        mr[i] = 0;
        for (int j = 0; j < N; j++) mw[i][j] = 0;
      end
      ms   = 2'b00;
      mcnt = 0;
    end else begin
      if (ena) begin
        for (int i = 0; i < N; i++) begin
          if (mr[i] > 0) begin
            mr[i]  = mr[i] - 1;
            mv[i]  = 0;
            nsp[i] = 1'b0;
          end else begin
            s = mv[i] - mv[i] / 8 + (ext_spike[i] ? 64 : 0);
            for (int j = 0; j < N; j++) if (ms[j]) s = s + mw[i][j];
            if (s < 0) s = 0;
            if (s > 255) s = 255;
            if (s >= 200) begin
              nsp[i] = 1'b1;
              mv[i]  = 0;
              mr[i]  = 3;
            end else begin
              nsp[i] = 1'b0;
              mv[i]  = s;
            end
          end
        end
        ms = nsp;
        if (nsp[N-1] && mcnt < 255) mcnt = mcnt + 1;
      end
      if (cfg_we) mw[cfg_addr[1]][cfg_addr[0]] = wval(cfg_wdata);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_spike", int'(spike), int'(ms));
      chk("cyc_spike_out", int'(spike_out), int'(ms[1]));
      chk("cyc_cnt", int'(spike_cnt), mcnt);
      chk("cyc_v0", int'(v0), mv[0]);
      chk("cyc_v1", int'(v1), mv[1]);
    end
  end

  task automatic step(input logic e, input logic [1:0] ext, input logic we = 1'b0,
                      input logic [1:0] a = 2'b00, input logic [3:0] d = 4'd0);
    @(negedge clk);
    ena       = e;
    ext_spike = ext;
    cfg_we    = we;
    cfg_addr  = a;
    cfg_wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ena = 1'b0; cfg_we = 1'b0; ext_spike = 2'b00;
    @(negedge clk);
    chk("rst_spike", int'(spike), 0);
    chk("rst_cnt", int'(spike_cnt), 0);
    chk("rst_v0", int'(v0), 0);
    chk("rst_v1", int'(v1), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int ev0 [8] = '{64, 120, 169, 0, 0, 0, 0, 64};
  int es0 [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
  logic [3:0] wnew;
  int v1_end;

  initial begin
    // Integration, spike, refractory hold, ena=0 hold.
    do_reset();
    for (int t = 0; t < 8; t++) begin
      step(1'b1, 2'b01);
      chk("s1_v0", int'(v0), ev0[t]);
      chk("s1_sp0", int'(spike[0]), es0[t]);
      if (t == 3) begin
        step(1'b0, 2'b01);
        step(1'b0, 2'b01);
        chk("s1_hold_sp0", int'(spike[0]), 1);
        chk("s1_hold_v0", int'(v0), 0);
      end
    end

    // Synaptic weight, written with ena low; rewrite on a tick edge.
    do_reset();
    step(1'b0, 2'b00, 1'b1, 2'b10, 4'd15);
    for (int t = 1; t <= 12; t++) begin
      if (t == 5) step(1'b1, 2'b01, 1'b1, 2'b10, 4'd3);
      else        step(1'b1, 2'b01);
      if (t == 5)  chk("s2_old_weight_v1", int'(v1), 15);
      if (t == 6)  chk("s2_leak_v1", int'(v1), 14);
      if (t == 12) chk("s2_new_weight_v1", int'(v1), 11);
    end

    // Counter saturation on the last neuron.
    do_reset();
    for (int t = 0; t < 2200; t++) begin
      step(1'b1, 2'b11);
      if (t == 3) chk("s3_first_cnt", int'(spike_cnt), 1);
    end
    chk("s3_sat_cnt", int'(spike_cnt), 255);
    step(1'b0, 2'b11);
    chk("s3_hold_cnt", int'(spike_cnt), 255);

    // Asynchronous reset while refractory.
    do_reset();
    for (int t = 0; t < 5; t++) step(1'b1, 2'b01);
    @(negedge clk);
    ena = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("s4_rst_spike", int'(spike), 0);
    #1 rst_n = 1'b1;
    step(1'b1, 2'b01);
    chk("s4_after_rst_v0", int'(v0), 64);
    step(1'b1, 2'b01);
    chk("s4_after_rst_v0b", int'(v0), 120);

    // Inhibitory (or plain excitatory) weight on a small potential.
`ifdef LIF_INHIBIT_EN
    wnew   = 4'b1000;
    v1_end = 0;
`else
    wnew   = 4'd8;
    v1_end = 13;
`endif
    do_reset();
    step(1'b0, 2'b00, 1'b1, 2'b10, 4'd5);
    for (int t = 1; t <= 12; t++) begin
      if (t == 5) step(1'b1, 2'b01, 1'b1, 2'b10, wnew);
      else        step(1'b1, 2'b01);
      if (t == 5)  chk("s5_v1_five", int'(v1), 5);
      if (t == 11) chk("s5_v1_kept", int'(v1), 5);
      if (t == 12) chk("s5_v1_final", int'(v1), v1_end);
    end
    step(1'b0, 2'b00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
